// File: rtl/python_sync_pkg.sv
// Python sync decoder shared definitions.
// Sync codes, code-type indices and FSM state encoding.
package python_sync_pkg;

  localparam logic [9:0] SYNC_FS  = 10'h2AA;
  localparam logic [9:0] SYNC_FE  = 10'h32A;
  localparam logic [9:0] SYNC_LS  = 10'h0AA;
  localparam logic [9:0] SYNC_LE  = 10'h12A;
  localparam logic [9:0] SYNC_BL  = 10'h015;
  localparam logic [9:0] SYNC_IMG = 10'h035;
  localparam logic [9:0] SYNC_CRC = 10'h059;
  localparam logic [9:0] SYNC_TR  = 10'h3A6;

  typedef enum logic [3:0] {
    CT_FS,
    CT_FE,
    CT_LS,
    CT_LE,
    CT_BL,
    CT_IMG,
    CT_CRC,
    CT_TR,
    CT_UNK
  } code_e;

  localparam int CT_NUM = 9;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FRAME = 2'd1;
  localparam logic [1:0] S_LINE  = 2'd2;

  // 8-bit links carry the upper 8 bits of the 10-bit code
  function automatic logic [9:0] sync_code(
    input logic [9:0] c10,
    input int         dw
  );
    return (dw == 8) ? (c10 >> 2) : c10;
  endfunction

endpackage

// File: rtl/python_sync_if.sv
// Kernel stream into, and decoded stream out of, the sync decoder.
// Master drives the kernel, slave is the decoder.
interface python_sync_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int CHANNEL_NUM = 4,
  parameter int CNT_WIDTH   = 16
);

  logic [DATA_WIDTH-1:0]             iv_sync;
  logic [DATA_WIDTH*CHANNEL_NUM-1:0] iv_pix_data;
  logic                              o_fval;
  logic                              o_lval;
  logic [DATA_WIDTH*CHANNEL_NUM-1:0] ov_pix_data;
  logic                              o_sync_err;
  logic                              o_width_err;
  logic [CNT_WIDTH-1:0]              ov_line_words;

  modport master (
    output iv_sync,
    output iv_pix_data,
    input  o_fval,
    input  o_lval,
    input  ov_pix_data,
    input  o_sync_err,
    input  o_width_err,
    input  ov_line_words
  );

  modport slave (
    input  iv_sync,
    input  iv_pix_data,
    output o_fval,
    output o_lval,
    output ov_pix_data,
    output o_sync_err,
    output o_width_err,
    output ov_line_words
  );

endinterface

// File: rtl/python_sync_classify.sv
// Maps a sync channel word to a one-hot code type.
// Unrecognised words land on CT_UNK.
import python_sync_pkg::*;

module python_sync_classify #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] iv_sync,
  output logic [CT_NUM-1:0]     ov_code
);

  localparam logic [DATA_WIDTH-1:0] K_FS =
    DATA_WIDTH'(sync_code(SYNC_FS, DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0] K_FE =
    DATA_WIDTH'(sync_code(SYNC_FE, DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0] K_LS =
    DATA_WIDTH'(sync_code(SYNC_LS, DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0] K_LE =
    DATA_WIDTH'(sync_code(SYNC_LE, DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0] K_BL =
    DATA_WIDTH'(sync_code(SYNC_BL, DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0] K_IMG =
    DATA_WIDTH'(sync_code(SYNC_IMG, DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0] K_CRC =
    DATA_WIDTH'(sync_code(SYNC_CRC, DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0] K_TR =
    DATA_WIDTH'(sync_code(SYNC_TR, DATA_WIDTH));

  always_comb begin
    ov_code = '0;
    unique case (iv_sync)
      K_FS:    ov_code[CT_FS]  = 1'b1;
      K_FE:    ov_code[CT_FE]  = 1'b1;
      K_LS:    ov_code[CT_LS]  = 1'b1;
      K_LE:    ov_code[CT_LE]  = 1'b1;
      K_BL:    ov_code[CT_BL]  = 1'b1;
      K_IMG:   ov_code[CT_IMG] = 1'b1;
      K_CRC:   ov_code[CT_CRC] = 1'b1;
      K_TR:    ov_code[CT_TR]  = 1'b1;
      default: ov_code[CT_UNK] = 1'b1;
    endcase
  end

endmodule

// File: rtl/python_sync_decoder.sv
// Python receive-side sync decoder: regenerates fval/lval,
// blanks non-image kernels and flags sync/width errors.
import python_sync_pkg::*;

module python_sync_decoder #(
  parameter int DATA_WIDTH  = 8,
  parameter int CHANNEL_NUM = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic          clk,
  input  logic          reset,
  python_sync_if.slave  bus
);

  localparam int PW = DATA_WIDTH * CHANNEL_NUM;

  localparam logic [DATA_WIDTH-1:0] K_TR =
    DATA_WIDTH'(sync_code(SYNC_TR, DATA_WIDTH));
  localparam logic [PW-1:0] TR_PAT = {CHANNEL_NUM{K_TR}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE =
    {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] sync_d, sync_q;
  logic [PW-1:0]         pix_d, pix_q;

  logic [1:0]            state_d, state_q;
  logic [CNT_WIDTH-1:0]  cnt_d, cnt_q;
  logic [CNT_WIDTH-1:0]  ref_d, ref_q;
  logic                  first_d, first_q;
  logic                  fval_d, fval_q;
  logic                  lval_d, lval_q;
  logic [PW-1:0]         pout_d, pout_q;
  logic                  serr_d, serr_q;
  logic                  werr_d, werr_q;
  logic [CNT_WIDTH-1:0]  words_d, words_q;

  logic [CT_NUM-1:0]     code;
  logic                  emit;
  logic                  start;
  logic                  close;

  python_sync_classify #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_classify (
    .iv_sync (sync_q),
    .ov_code (code)
  );

  always_comb begin
    sync_d = bus.iv_sync;
    pix_d  = bus.iv_pix_data;
  end

  always_comb begin
    state_d = state_q;
    first_d = first_q;
    emit    = 1'b0;
    start   = 1'b0;
    close   = 1'b0;
    serr_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        unique case (1'b1)
          code[CT_FS]: begin
            emit    = 1'b1;
            start   = 1'b1;
            first_d = 1'b1;
            state_d = S_LINE;
          end
          code[CT_LS], code[CT_IMG],
          code[CT_LE], code[CT_FE]:
            serr_d = 1'b1;
          code[CT_TR], code[CT_CRC],
          code[CT_BL], code[CT_UNK]: ;
          default: ;
        endcase
      end
      S_FRAME: begin
        unique case (1'b1)
          code[CT_LS]: begin
            emit    = 1'b1;
            start   = 1'b1;
            state_d = S_LINE;
          end
          // unexpected FS restarts the frame
          code[CT_FS]: begin
            serr_d  = 1'b1;
            emit    = 1'b1;
            start   = 1'b1;
            first_d = 1'b1;
            state_d = S_LINE;
          end
          code[CT_IMG], code[CT_LE],
          code[CT_FE], code[CT_UNK]:
            serr_d = 1'b1;
          code[CT_TR], code[CT_CRC],
          code[CT_BL]: ;
          default: ;
        endcase
      end
      S_LINE: begin
        unique case (1'b1)
          code[CT_IMG]: emit = 1'b1;
          code[CT_LE]: begin
            emit    = 1'b1;
            close   = 1'b1;
            state_d = S_FRAME;
          end
          code[CT_FE]: begin
            emit    = 1'b1;
            close   = 1'b1;
            state_d = S_IDLE;
          end
          default: begin
            serr_d  = 1'b1;
            state_d = S_FRAME;
          end
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    ref_d   = ref_q;
    words_d = words_q;
    werr_d  = 1'b0;
    if (start) begin
      cnt_d = CNT_ONE;
    end else if (emit && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
    if (close) begin
      words_d = cnt_d;
      if (first_q) begin
        ref_d = cnt_d;
      end else begin
        werr_d = (cnt_d != ref_q);
      end
    end
  end

  // first_q clears once the reference width is taken
  logic first_nx;
  always_comb begin
    first_nx = first_d;
    if (close && first_q) begin
      first_nx = 1'b0;
    end
  end

  always_comb begin
    fval_d = emit || (state_d != S_IDLE);
    lval_d = emit;
    pout_d = emit ? pix_q : TR_PAT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= K_TR;
      pix_q   <= '0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ref_q   <= '0;
      first_q <= 1'b0;
      fval_q  <= 1'b0;
      lval_q  <= 1'b0;
      pout_q  <= TR_PAT;
      serr_q  <= 1'b0;
      werr_q  <= 1'b0;
      words_q <= '0;
    end else begin
      sync_q  <= sync_d;
      pix_q   <= pix_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ref_q   <= ref_d;
      first_q <= first_nx;
      fval_q  <= fval_d;
      lval_q  <= lval_d;
      pout_q  <= pout_d;
      serr_q  <= serr_d;
      werr_q  <= werr_d;
      words_q <= words_d;
    end
  end

  assign bus.o_fval        = fval_q;
  assign bus.o_lval        = lval_q;
  assign bus.ov_pix_data   = pout_q;
  assign bus.o_sync_err    = serr_q;
  assign bus.o_width_err   = werr_q;
  assign bus.ov_line_words = words_q;

endmodule

// File: tb/tb_python_sync_decoder.sv
// Scoreboard bench for python_sync_decoder, 10-bit x 4 lanes.
// Expected outputs are queued at drive time, checked 2 cycles on.
module tb_python_sync_decoder;

  localparam logic [9:0] FS  = 10'h2AA;
  localparam logic [9:0] FE  = 10'h32A;
  localparam logic [9:0] LS  = 10'h0AA;
  localparam logic [9:0] LE  = 10'h12A;
  localparam logic [9:0] IMG = 10'h035;
  localparam logic [9:0] CRC = 10'h059;
  localparam logic [9:0] TR  = 10'h3A6;
  localparam logic [39:0] TRP = {4{10'h3A6}};

  typedef struct {
    string        tag;
    int           due;
    logic         lval;
    logic         fval;
    int           serr;
    logic         werr;
    logic [15:0]  words;
    logic [39:0]  data;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q[$];
  exp_t e;

  python_sync_if #(
    .DATA_WIDTH  (10),
    .CHANNEL_NUM (4),
    .CNT_WIDTH   (16)
  ) bus ();

  python_sync_decoder #(
    .DATA_WIDTH  (10),
    .CHANNEL_NUM (4),
    .CNT_WIDTH   (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (q.size() != 0 && q[0].due == cyc) begin
      e = q.pop_front();
      n_chk++;
      if (bus.o_lval !== e.lval) begin
        n_fail++;
        $display("FAIL %s lval got %0b want %0b",
                 e.tag, bus.o_lval, e.lval);
      end
      n_chk++;
      if (bus.o_fval !== e.fval) begin
        n_fail++;
        $display("FAIL %s fval got %0b want %0b",
                 e.tag, bus.o_fval, e.fval);
      end
      if (e.serr >= 0) begin
        n_chk++;
        if (bus.o_sync_err !== e.serr[0]) begin
          n_fail++;
          $display("FAIL %s sync_err got %0b want %0b",
                   e.tag, bus.o_sync_err, e.serr[0]);
        end
      end
      n_chk++;
      if (bus.o_width_err !== e.werr) begin
        n_fail++;
        $display("FAIL %s width_err got %0b want %0b",
                 e.tag, bus.o_width_err, e.werr);
      end
      n_chk++;
      if (bus.ov_line_words !== e.words) begin
        n_fail++;
        $display("FAIL %s line_words got %0d want %0d",
                 e.tag, bus.ov_line_words, e.words);
      end
      n_chk++;
      if (bus.ov_pix_data !== e.data) begin
        n_fail++;
        $display("FAIL %s pix_data got %h want %h",
                 e.tag, bus.ov_pix_data, e.data);
      end
    end
  end

  // Drive one kernel; rst replaces in-flight expectations
  task automatic drv(
    input string      tag,
    input logic [9:0] s,
    input bit         rst,
    input bit         lv,
    input bit         fv,
    input int         se,
    input bit         we,
    input int         w
  );
    exp_t x;
    logic [39:0] d;
    @(posedge clk);
    #1;
    d = {8'($urandom), 32'($urandom)};
    reset = rst;
    bus.iv_sync = s;
    bus.iv_pix_data = d;
    if (rst) begin
      while (q.size() != 0 && q[$].due > cyc) void'(q.pop_back());
      x = '{tag: {tag, "_r"}, due: cyc + 1, lval: 1'b0,
            fval: 1'b0, serr: 0, werr: 1'b0, words: 16'd0,
            data: TRP};
      q.push_back(x);
    end
    x = '{tag: tag, due: cyc + 2, lval: lv, fval: fv,
          serr: se, werr: we, words: 16'(w),
          data: lv ? d : TRP};
    q.push_back(x);
  endtask

  task automatic test_reset();
    drv("rst0", TR, 1, 0, 0, 0, 0, 0);
    drv("rst1", TR, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    n_chk++;
    if (bus.o_fval !== 1'b0 || bus.o_lval !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_vals fval/lval got %0b%0b want 00",
               bus.o_fval, bus.o_lval);
    end
    n_chk++;
    if (bus.ov_pix_data !== TRP) begin
      n_fail++;
      $display("FAIL reset_pix got %h want %h",
               bus.ov_pix_data, TRP);
    end
    n_chk++;
    if (bus.ov_line_words !== 16'd0 || bus.o_sync_err !== 1'b0
        || bus.o_width_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_misc words %0d serr %0b werr %0b want 0",
               bus.ov_line_words, bus.o_sync_err, bus.o_width_err);
    end
    drv("idle0", TR, 0, 0, 0, 0, 0, 0);
    drv("idle1", TR, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_normal_frame();
    drv("nf_tr0", TR,  0, 0, 0, 0, 0, 0);
    drv("nf_fs",  FS,  0, 1, 1, 0, 0, 0);
    drv("nf_img", IMG, 0, 1, 1, 0, 0, 0);
    drv("nf_le",  LE,  0, 1, 1, 0, 0, 3);
    drv("nf_crc", CRC, 0, 0, 1, 0, 0, 3);
    drv("nf_tr1", TR,  0, 0, 1, 0, 0, 3);
    drv("nf_ls",  LS,  0, 1, 1, 0, 0, 3);
    drv("nf_im2", IMG, 0, 1, 1, 0, 0, 3);
    drv("nf_fe",  FE,  0, 1, 1, 0, 0, 3);
    drv("nf_crc2", CRC, 0, 0, 0, 0, 0, 3);
  endtask

  task automatic test_idle_illegal();
    drv("ii_ls", LS, 0, 0, 0, 1, 0, 3);
    drv("ii_tr", TR, 0, 0, 0, 0, 0, 3);
  endtask

  task automatic test_width_mismatch();
    drv("wm_fs",   FS,  0, 1, 1, 0, 0, 3);
    drv("wm_img",  IMG, 0, 1, 1, 0, 0, 3);
    drv("wm_le",   LE,  0, 1, 1, 0, 0, 3);
    drv("wm_ls",   LS,  0, 1, 1, 0, 0, 3);
    drv("wm_img1", IMG, 0, 1, 1, 0, 0, 3);
    drv("wm_img2", IMG, 0, 1, 1, 0, 0, 3);
    drv("wm_fe",   FE,  0, 1, 1, 0, 1, 4);
    drv("wm_tr",   TR,  0, 0, 0, 0, 0, 4);
  endtask

  task automatic test_abort();
    drv("ab_fs",   FS,  0, 1, 1, 0, 0, 4);
    drv("ab_img",  IMG, 0, 1, 1, 0, 0, 4);
    drv("ab_le",   LE,  0, 1, 1, 0, 0, 3);
    drv("ab_ls",   LS,  0, 1, 1, 0, 0, 3);
    drv("ab_img1", IMG, 0, 1, 1, 0, 0, 3);
    drv("ab_tr",   TR,  0, 0, 1, 1, 0, 3);
    drv("ab_ls2",  LS,  0, 1, 1, 0, 0, 3);
    drv("ab_img2", IMG, 0, 1, 1, 0, 0, 3);
    drv("ab_le2",  LE,  0, 1, 1, 0, 0, 3);
    drv("ab_ls3",  LS,  0, 1, 1, 0, 0, 3);
    drv("ab_img3", IMG, 0, 1, 1, 0, 0, 3);
    drv("ab_fe",   FE,  0, 1, 1, 0, 0, 3);
    drv("ab_end",  TR,  0, 0, 0, 0, 0, 3);
  endtask

  task automatic test_reset_mid_line();
    drv("rm_fs",   FS,  0, 1, 1, 0, 0, 3);
    drv("rm_img",  IMG, 0, 1, 1, 0, 0, 3);
    drv("rm_rst",  IMG, 1, 0, 0, 0, 0, 0);
    drv("rm_img1", IMG, 0, 0, 0, -1, 0, 0);
    drv("rm_le",   LE,  0, 0, 0, 1, 0, 0);
    drv("rm_fs2",  FS,  0, 1, 1, 0, 0, 0);
    drv("rm_img2", IMG, 0, 1, 1, 0, 0, 0);
    drv("rm_le2",  LE,  0, 1, 1, 0, 0, 3);
    drv("rm_ls",   LS,  0, 1, 1, 0, 0, 3);
    drv("rm_img3", IMG, 0, 1, 1, 0, 0, 3);
    drv("rm_fe",   FE,  0, 1, 1, 0, 0, 3);
    drv("rm_tr",   TR,  0, 0, 0, 0, 0, 3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.iv_sync = TR;
    bus.iv_pix_data = '0;
    test_reset();
    test_normal_frame();
    test_idle_illegal();
    test_width_mismatch();
    test_abort();
    test_reset_mid_line();
    repeat (4) @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending got %0d want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
